// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types, segment geometry and G/P merge for the pipelined CLA
package cla_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_SBB = 2'd3
    } op_t;

    localparam int SEG = 16;
    localparam int GRP = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Combine a higher-order generate/propagate pair with the lower-order pair below it.
    function automatic gp_t gp_merge(input logic g_hi, input logic p_hi,
                                     input logic g_lo, input logic p_lo);
        gp_t r;
        r.g = g_hi | (p_hi & g_lo);
        r.p = p_hi & p_lo;
        return r;
    endfunction

endpackage

// File: rtl/cla_seg16.sv
// rtl/cla_seg16.sv - combinational 16-bit slice: four 4-bit lookahead groups plus a group-level lookahead
module cla_seg16
    import cla_pkg::*;
(
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           a_msb,
    output logic           b_msb
);

    localparam int NG = SEG / GRP;

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG-1:0] c;
    logic [NG:0]    gc;
    gp_t            grp [NG];
    gp_t            acc;

    always_comb begin
        g = a & b;
        p = a | b;
        for (int i = 0; i < NG; i++) begin
            grp[i] = '{g: g[i*GRP], p: p[i*GRP]};
            for (int j = 1; j < GRP; j++)
                grp[i] = gp_merge(g[i*GRP+j], p[i*GRP+j], grp[i].g, grp[i].p);
        end
        // Every group carry is formed from the slice carry-in, never from the previous group.
        gc[0] = ci;
        acc   = '{g: 1'b0, p: 1'b1};
        for (int i = 0; i < NG; i++) begin
            acc     = gp_merge(grp[i].g, grp[i].p, acc.g, acc.p);
            gc[i+1] = acc.g | (acc.p & ci);
        end
        for (int i = 0; i < NG; i++) begin
            acc = '{g: 1'b0, p: 1'b1};
            for (int j = 0; j < GRP; j++) begin
                c[i*GRP+j] = acc.g | (acc.p & gc[i]);
                acc        = gp_merge(g[i*GRP+j], p[i*GRP+j], acc.g, acc.p);
            end
        end
        s = a ^ b ^ c;
    end

    assign co    = gc[NG];
    assign a_msb = a[SEG-1];
    assign b_msb = b[SEG-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined CLA add/subtract, one 16-bit segment per stage, valid/ready both sides
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N = WIDTH / SEG;

    if (SEG != 16 || WIDTH % 16 != 0 || WIDTH < 16 || WIDTH > 128) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a multiple of 16 in 16..128 and SEG must be 16");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic [WIDTH-1:0] a_d    [N];
    logic [WIDTH-1:0] b_d    [N];
    logic [WIDTH-1:0] s_prev [N];
    logic [WIDTH-1:0] s_d    [N];
    logic [N-1:0]     seg_ci;
    logic [N-1:0]     v_d;
    logic [N-1:0]     c_d;
    logic [N-1:0]     a_msb;
    logic [N-1:0]     b_msb;

    logic [WIDTH-1:0] a_q [N];
    logic [WIDTH-1:0] b_q [N];
    logic [WIDTH-1:0] s_q [N];
    logic [N-1:0]     v_q;
    logic [N-1:0]     c_q;
    logic             ovf_d, zero_d;
    logic             ovf_q, zero_q;
    logic             unused_msb;

    always_comb begin
        b_eff = b;
        c0    = 1'b0;
        case (op)
            OP_SUB: begin
                b_eff = ~b;
                c0    = 1'b1;
            end
            OP_ADC: c0 = cin;
            OP_SBB: begin
                b_eff = ~b;
                c0    = ~cin;
            end
            default: ;
        endcase
    end

    assign en       = out_ready || !v_q[N-1];
    assign in_ready = en;

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic [SEG-1:0] seg_s;

        if (k == 0) begin : g_first
            // Bubbles enter as all-zero operands so idle slots never show stale data.
            assign a_d[0]    = in_valid ? a : '0;
            assign b_d[0]    = in_valid ? b_eff : '0;
            assign s_prev[0] = '0;
            assign seg_ci[0] = in_valid & c0;
            assign v_d[0]    = in_valid;
        end else begin : g_next
            assign a_d[k]    = a_q[k-1];
            assign b_d[k]    = b_q[k-1];
            assign s_prev[k] = s_q[k-1];
            assign seg_ci[k] = c_q[k-1];
            assign v_d[k]    = v_q[k-1];
        end

        cla_seg16 u_seg (
            .a     (a_d[k][k*SEG +: SEG]),
            .b     (b_d[k][k*SEG +: SEG]),
            .ci    (seg_ci[k]),
            .s     (seg_s),
            .co    (c_d[k]),
            .a_msb (a_msb[k]),
            .b_msb (b_msb[k])
        );

        // Segment k of the partial sum is still zero here, so OR-ing inserts the new slice.
        assign s_d[k] = s_prev[k] | (WIDTH'(seg_s) << (k * SEG));
    end

    assign ovf_d      = (a_msb[N-1] == b_msb[N-1]) && (s_d[N-1][WIDTH-1] != a_msb[N-1]);
    assign zero_d     = v_d[N-1] && (s_d[N-1] == '0);
    assign unused_msb = ^{a_msb, b_msb};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < N; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            v_q    <= v_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[N-1];
    assign sum       = s_q[N-1];
    assign cout      = c_q[N-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - randomized scoreboard bench for cla_pipe_addsub at WIDTH 32 and 64
module tb_cla_pipe_addsub;
    import cla_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    function automatic res_t model(input int w, input logic [127:0] a, input logic [127:0] b,
                                   input op_t op, input logic cin);
        logic [128:0] full;
        logic [127:0] mask, bb;
        logic         c0;
        res_t         r;
        mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        bb   = (op == OP_SUB || op == OP_SBB) ? (~b & mask) : b;
        c0   = (op == OP_SUB) ? 1'b1 : (op == OP_ADC) ? cin : (op == OP_SBB) ? ~cin : 1'b0;
        full = {1'b0, a} + {1'b0, bb} + {128'd0, c0};
        r.sum  = full[127:0] & mask;
        r.cout = full[w];
        r.ovf  = (a[w-1] == bb[w-1]) && (r.sum[w-1] != a[w-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    logic        s_rst, s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout, s_ovf, s_zero;
    logic [31:0] s_a, s_b, s_sum;
    op_t         s_op;

    logic        w_rst, w_in_valid, w_in_ready, w_cin, w_out_valid, w_out_ready, w_cout, w_ovf, w_zero;
    logic [63:0] w_a, w_b, w_sum;
    op_t         w_op;

    cla_pipe_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .op(s_op), .cin(s_cin),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .ovf(s_ovf), .zero(s_zero)
    );

    cla_pipe_addsub #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(w_rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .op(w_op), .cin(w_cin),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .ovf(w_ovf), .zero(w_zero)
    );

    bit          sb32_on = 0, sb64_on = 0, stall32 = 0;
    int          sent32 = 0, got32 = 0, sent64 = 0, got64 = 0;
    res_t        q32[$], q64[$];
    res_t        e32, e64;
    logic [35:0] cur32, hold32;

    always @(negedge clk) begin
        if (sb32_on) begin
            cur32 = {s_out_valid, s_sum, s_cout, s_ovf, s_zero};
            check("in_ready32", s_in_ready, !(s_out_valid && !s_out_ready));
            if (stall32) check("stall_hold32", cur32, hold32);
            stall32 = s_out_valid && !s_out_ready;
            hold32  = cur32;
            if (s_in_valid && s_in_ready) begin
                q32.push_back(model(32, s_a, s_b, s_op, s_cin));
                sent32++;
            end
            if (s_out_valid && s_out_ready) begin
                check("q32_nonempty", q32.size() > 0, 1);
                if (q32.size() > 0) begin
                    e32 = q32.pop_front();
                    check("res32", {s_sum, s_cout, s_ovf, s_zero}, {e32.sum[31:0], e32.cout, e32.ovf, e32.zero});
                end
                got32++;
            end
        end else begin
            stall32 = 0;
        end
    end

    always @(negedge clk) begin
        if (sb64_on) begin
            if (w_in_valid && w_in_ready) begin
                q64.push_back(model(64, w_a, w_b, w_op, w_cin));
                sent64++;
            end
            if (w_out_valid && w_out_ready) begin
                check("q64_nonempty", q64.size() > 0, 1);
                if (q64.size() > 0) begin
                    e64 = q64.pop_front();
                    check("res64", {w_sum, w_cout, w_ovf, w_zero}, {e64.sum[63:0], e64.cout, e64.ovf, e64.zero});
                end
                got64++;
            end
        end
    end

    task automatic directed32(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input op_t op, input logic cin, input logic [31:0] e_sum,
                              input logic e_cout, input logic e_ovf, input logic e_zero);
        int lat;
        s_in_valid  = 1'b1;
        s_a         = a;
        s_b         = b;
        s_op        = op;
        s_cin       = cin;
        s_out_ready = 1'b1;
        check({tag, "_in_ready"}, s_in_ready, 1);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_result"}, {s_sum, s_cout, s_ovf, s_zero}, {e_sum, e_cout, e_ovf, e_zero});
        @(posedge clk); #1;
    endtask

    bit pat [4];

    initial begin
        int lat;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        s_rst = 1'b1; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_op = OP_ADD; s_cin = 1'b0; s_out_ready = 1'b0;
        w_rst = 1'b1; w_in_valid = 1'b0; w_a = '0; w_b = '0; w_op = OP_ADD; w_cin = 1'b0; w_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        s_rst = 1'b0;
        w_rst = 1'b0;

        check("rst_out_valid32", s_out_valid, 0);
        check("rst_outputs32", {s_sum, s_cout, s_ovf, s_zero}, 0);
        check("rst_in_ready32", s_in_ready, 1);
        check("rst_out_valid64", w_out_valid, 0);
        check("rst_outputs64", {w_sum, w_cout, w_ovf, w_zero}, 0);

        directed32("add_seg_carry", 32'h0000FFFF, 32'h00000001, OP_ADD, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        directed32("sub_borrow",    32'd5,        32'd7,        OP_SUB, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        directed32("sub_ovf",       32'h80000000, 32'h00000001, OP_SUB, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        directed32("adc_wrap",      32'hFFFFFFFF, 32'h00000000, OP_ADC, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        directed32("sbb_borrow",    32'h00000000, 32'h00000000, OP_SBB, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        directed32("add_ovf",       32'h7FFFFFFF, 32'h00000001, OP_ADD, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);

        sb32_on = 1'b1;
        for (int cyc = 0; cyc < 200 && got32 < 8; cyc++) begin
            s_out_ready = pat[cyc % 4];
            s_in_valid  = (sent32 < 8);
            s_a   = $urandom;
            s_b   = $urandom;
            s_op  = op_t'($urandom_range(0, 3));
            s_cin = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        sb32_on    = 1'b0;
        check("stream32_delivered", got32, 8);
        check("stream32_drained", q32.size(), 0);

        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_a = 32'h11111111; s_b = 32'h22222222; s_op = OP_ADD;
        @(posedge clk); #1;
        s_a = 32'h33333333; s_b = 32'h44444444;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("inflight_out_valid", s_out_valid, 1);
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst       = 1'b0;
        s_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("post_rst_quiet", {s_out_valid, s_sum, s_cout, s_ovf, s_zero}, 0);
            @(posedge clk); #1;
        end
        directed32("post_rst_beat", 32'h12345678, 32'h11111111, OP_ADD, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);

        sb64_on     = 1'b1;
        w_in_valid  = 1'b1;
        w_a = {$urandom, $urandom}; w_b = {$urandom, $urandom}; w_op = OP_ADD; w_cin = 1'b0;
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        lat = 1;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency64", lat, 4);
        @(posedge clk); #1;

        for (int cyc = 0; cyc < 30000 && got64 < 1001; cyc++) begin
            w_in_valid  = (sent64 < 1001) && ($urandom_range(0, 7) != 0);
            w_a   = ($urandom_range(0, 3) == 0) ? 64'hFFFFFFFF_FFFFFFFF : {$urandom, $urandom};
            w_b   = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            w_op  = op_t'($urandom_range(0, 3));
            w_cin = 1'($urandom_range(0, 1));
            w_out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        sb64_on    = 1'b0;
        check("stream64_delivered", got64, 1001);
        check("stream64_drained", q64.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
